// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: EX->MEM and MEM->WB bundles, load opcodes.
// MEM_UNALIGNED_LOAD_EN adds the rt_value field used by LWL/LWR merging.
package memory_stage_pkg;

  localparam int CANCEL_W_DEF = 2;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6
  } ld_op_t;

  typedef struct packed {
    logic       ex;
    logic [4:0] code;
  } exc_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        rf_we;
    logic [31:0] result;
    logic        mem_req;
    logic        is_load;
    ld_op_t      ld_op;
    logic [2:0]  c0_op;
    logic [1:0]  tlb_op;
    logic [4:0]  cache_op;
    logic [31:0] phy_addr;
    exc_t        exception;
`ifdef MEM_UNALIGNED_LOAD_EN
    logic [31:0] rt_value;
`endif
  } es_to_ms_bus_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [3:0]  rf_we;
    logic [31:0] result;
    logic [2:0]  c0_op;
    logic [1:0]  tlb_op;
    logic [4:0]  cache_op;
    logic [31:0] phy_addr;
    exc_t        exception;
  } ms_to_ws_bus_t;

endpackage

// File: rtl/memory_stage_load_align.sv
// Combinational load lane select and sign/zero extension.
// MEM_UNALIGNED_LOAD_EN enables LWL/LWR merging with the old rt value.
module load_align
  import memory_stage_pkg::*;
(
  input  ld_op_t      ld_op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rdata_i,
`ifdef MEM_UNALIGNED_LOAD_EN
  input  logic [31:0] rt_value_i,
`endif
  output logic [31:0] value_o,
  output logic [3:0]  byte_we_o
);

  logic [7:0]  b;
  logic [15:0] h;

  assign b = rdata_i[8*addr_i +: 8];
  assign h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

`ifdef MEM_UNALIGNED_LOAD_EN
  logic [4:0] lsh;
  logic [4:0] rsh;

  // LWL fills bytes from the top down, LWR from the bottom up.
  assign lsh = {~addr_i, 3'b000};
  assign rsh = {addr_i, 3'b000};
`endif

  always_comb begin
    value_o   = rdata_i;
    byte_we_o = 4'hf;
    unique case (ld_op_i)
      LD_LB:  value_o = {{24{b[7]}}, b};
      LD_LBU: value_o = {24'h0, b};
      LD_LH:  value_o = {{16{h[15]}}, h};
      LD_LHU: value_o = {16'h0, h};
`ifdef MEM_UNALIGNED_LOAD_EN
      LD_LWL: begin
        value_o   = (rdata_i << lsh)
                  | (rt_value_i & ~(32'hffff_ffff << lsh));
        byte_we_o = 4'hf << ~addr_i;
      end
      LD_LWR: begin
        value_o   = (rdata_i >> rsh)
                  | (rt_value_i & ~(32'hffff_ffff >> rsh));
        byte_we_o = 4'hf >> addr_i;
      end
`endif
      default: value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: waits on data responses, aligns loads, drops cancelled responses.
// MEM_UNALIGNED_LOAD_EN enables LWL/LWR merge and per-byte write enables.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int CANCEL_W = CANCEL_W_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          es_to_valid,
  output logic          ms_allowin,
  input  es_to_ms_bus_t es_to_ms_bus,
  input  logic          es_req_inflight,
  output logic          ms_to_valid,
  input  logic          ws_allowin,
  output ms_to_ws_bus_t ms_to_ws_bus,
  input  logic          pipeline_flush,
  input  logic          data_ok,
  input  logic [31:0]   data_rdata,
  output logic [4:0]    ms_dest,
  output logic [31:0]   ms_result,
  output logic          ms_load_stall
);

  localparam logic [CANCEL_W:0] CNT_MAX =
    (CANCEL_W+1)'((1 << CANCEL_W) - 1);

  logic                ms_valid_q, ms_valid_d;
  es_to_ms_bus_t       bus_q, bus_d;
  logic                buf_valid_q, buf_valid_d;
  logic [31:0]         data_buf_q, data_buf_d;
  logic [CANCEL_W-1:0] cancel_cnt_q, cancel_cnt_d;

  logic        need_resp, resp_now, ready_go, leave;
  logic        load_res, drop_cur, cnt_dec;
  logic [31:0] rdata_sel, load_val, final_res;
  logic [3:0]  byte_we;
  logic [CANCEL_W:0] cnt_inc, cnt_sum;

  assign need_resp  = bus_q.mem_req & ~bus_q.exception.ex;
  assign resp_now   = data_ok & (cancel_cnt_q == '0);
  assign ready_go   = ~need_resp | buf_valid_q | resp_now;
  assign ms_to_valid = ms_valid_q & ready_go;
  assign leave      = ms_to_valid & ws_allowin;
  assign ms_allowin = ~ms_valid_q | (ready_go & ws_allowin);

  // Buffered data wins; otherwise the live response passes straight through.
  assign rdata_sel = buf_valid_q ? data_buf_q : data_rdata;

  load_align u_align (
    .ld_op_i    (bus_q.ld_op),
    .addr_i     (bus_q.result[1:0]),
    .rdata_i    (rdata_sel),
`ifdef MEM_UNALIGNED_LOAD_EN
    .rt_value_i (bus_q.rt_value),
`endif
    .value_o    (load_val),
    .byte_we_o  (byte_we)
  );

  assign load_res  = bus_q.is_load & need_resp;
  assign final_res = load_res ? load_val : bus_q.result;

  assign drop_cur = ms_valid_q & need_resp & ~buf_valid_q & ~data_ok;
  assign cnt_dec  = data_ok & (cancel_cnt_q != '0);
  assign cnt_inc  = pipeline_flush
                  ? (CANCEL_W+1)'(drop_cur) + (CANCEL_W+1)'(es_req_inflight)
                  : '0;
  assign cnt_sum  = {1'b0, cancel_cnt_q} + cnt_inc
                  - (CANCEL_W+1)'(cnt_dec);

  always_comb begin
    ms_valid_d   = ms_valid_q;
    bus_d        = bus_q;
    buf_valid_d  = buf_valid_q;
    data_buf_d   = data_buf_q;
    cancel_cnt_d = (cnt_sum > CNT_MAX) ? CNT_MAX[CANCEL_W-1:0]
                                       : cnt_sum[CANCEL_W-1:0];
    if (pipeline_flush) ms_valid_d = 1'b0;
    else if (ms_allowin) ms_valid_d = es_to_valid;
    if (es_to_valid & ms_allowin) bus_d = es_to_ms_bus;
    if (pipeline_flush | leave) begin
      buf_valid_d = 1'b0;
    end else if (ms_valid_q & need_resp & ~buf_valid_q & resp_now) begin
      buf_valid_d = 1'b1;
      data_buf_d  = data_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q   <= 1'b0;
      bus_q        <= '0;
      buf_valid_q  <= 1'b0;
      data_buf_q   <= '0;
      cancel_cnt_q <= '0;
    end else begin
      ms_valid_q   <= ms_valid_d;
      bus_q        <= bus_d;
      buf_valid_q  <= buf_valid_d;
      data_buf_q   <= data_buf_d;
      cancel_cnt_q <= cancel_cnt_d;
    end
  end

  cancel_no_sat: assert property (
    @(posedge clk) disable iff (reset) cnt_sum <= CNT_MAX
  );

  assign ms_to_ws_bus.pc        = bus_q.pc;
  assign ms_to_ws_bus.dest      = bus_q.dest;
  assign ms_to_ws_bus.rf_we     = ~bus_q.rf_we ? 4'h0
                                : (load_res ? byte_we : 4'hf);
  assign ms_to_ws_bus.result    = final_res;
  assign ms_to_ws_bus.c0_op     = bus_q.c0_op;
  assign ms_to_ws_bus.tlb_op    = bus_q.tlb_op;
  assign ms_to_ws_bus.cache_op  = bus_q.cache_op;
  assign ms_to_ws_bus.phy_addr  = bus_q.phy_addr;
  assign ms_to_ws_bus.exception = bus_q.exception;

  assign ms_dest       = (ms_valid_q & bus_q.rf_we) ? bus_q.dest : 5'd0;
  assign ms_result     = final_res;
  assign ms_load_stall = ms_valid_q & bus_q.is_load & ~ready_go;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus a
// randomized load/store stream checked against a byte-level model.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic          es_to_valid;
  logic          ms_allowin;
  es_to_ms_bus_t es_bus;
  logic          es_req_inflight;
  logic          ms_to_valid;
  logic          ws_allowin;
  ms_to_ws_bus_t ws_bus;
  logic          pipeline_flush;
  logic          data_ok;
  logic [31:0]   data_rdata;
  logic [4:0]    ms_dest;
  logic [31:0]   ms_result;
  logic          ms_load_stall;

  int n_cmp = 0;
  int n_err = 0;

  memory_stage dut (
    .clk             (clk),
    .reset           (reset),
    .es_to_valid     (es_to_valid),
    .ms_allowin      (ms_allowin),
    .es_to_ms_bus    (es_bus),
    .es_req_inflight (es_req_inflight),
    .ms_to_valid     (ms_to_valid),
    .ws_allowin      (ws_allowin),
    .ms_to_ws_bus    (ws_bus),
    .pipeline_flush  (pipeline_flush),
    .data_ok         (data_ok),
    .data_rdata      (data_rdata),
    .ms_dest         (ms_dest),
    .ms_result       (ms_result),
    .ms_load_stall   (ms_load_stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    es_to_valid     = 1'b0;
    es_req_inflight = 1'b0;
    pipeline_flush  = 1'b0;
    data_ok         = 1'b0;
    data_rdata      = $urandom;
    ws_allowin      = 1'b1;
  endtask

  function automatic es_to_ms_bus_t mk(ld_op_t op, logic ld, logic req,
                                       logic ex, logic [31:0] va,
                                       logic [4:0] d, logic we);
    es_to_ms_bus_t b;
    b = '0;
    b.pc             = $urandom;
    b.dest           = d;
    b.rf_we          = we;
    b.result         = va;
    b.mem_req        = req;
    b.is_load        = ld;
    b.ld_op          = op;
    b.phy_addr       = va;
    b.exception.ex   = ex;
    b.exception.code = ex ? 5'd4 : 5'd0;
`ifdef MEM_UNALIGNED_LOAD_EN
    b.rt_value       = $urandom;
`endif
    return b;
  endfunction

  function automatic logic [31:0] get_rt(es_to_ms_bus_t b);
`ifdef MEM_UNALIGNED_LOAD_EN
    return b.rt_value;
`else
    return 32'h0 & {32{b.rf_we}};
`endif
  endfunction

  // Reference: build the result byte by byte from the memory word.
  function automatic logic [35:0] ref_load(ld_op_t op, logic [1:0] a,
                                           logic [31:0] d,
                                           logic [31:0] rt);
    logic [7:0]  by[4];
    logic [31:0] v;
    logic [15:0] hw;
    logic [3:0]  we;
    int s;
    for (int i = 0; i < 4; i++) by[i] = d[8*i +: 8];
    hw = {by[{a[1], 1'b1}], by[{a[1], 1'b0}]};
    v  = d;
    we = 4'hf;
    s  = 3 - int'(a);
    case (op)
      LD_LB:  v = {{24{by[a][7]}}, by[a]};
      LD_LBU: v = {24'h0, by[a]};
      LD_LH:  v = {{16{hw[15]}}, hw};
      LD_LHU: v = {16'h0, hw};
`ifdef MEM_UNALIGNED_LOAD_EN
      LD_LWL: for (int i = 0; i < 4; i++) begin
        v[8*i +: 8] = (i >= s) ? by[i-s] : rt[8*i +: 8];
        we[i]       = (i >= s);
      end
      LD_LWR: for (int i = 0; i < 4; i++) begin
        v[8*i +: 8] = (i <= s) ? by[i+int'(a)] : rt[8*i +: 8];
        we[i]       = (i <= s);
      end
`endif
      default: v = d;
    endcase
    return {we, v};
  endfunction

  task automatic issue(input es_to_ms_bus_t b);
    es_bus      = b;
    es_to_valid = 1'b1;
    step();
    es_to_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    es_bus = '0;
    repeat (2) step();
    if ({ms_to_valid, ms_allowin, ms_load_stall} !== 3'b010) begin
      n_err++;
      $display("FAIL reset_ctrl got %b want 010",
               {ms_to_valid, ms_allowin, ms_load_stall});
    end
    n_cmp++;
    if ({ms_dest, ms_result, ws_bus.rf_we} !== 41'h0) begin
      n_err++;
      $display("FAIL reset_data dest=%0d res=%h we=%h want 0",
               ms_dest, ms_result, ws_bus.rf_we);
    end
    n_cmp++;
    reset = 1'b0;
    step();
  endtask

  task automatic test_lw_latency();
    idle();
    issue(mk(LD_LW, 1, 1, 0, 32'h1000, 5'd5, 1));
    repeat (2) begin
      if ({ms_to_valid, ms_load_stall, ms_dest} !== {2'b01, 5'd5}) begin
        n_err++;
        $display("FAIL lw_wait valid/stall/dest got %b/%b/%0d want 0/1/5",
                 ms_to_valid, ms_load_stall, ms_dest);
      end
      n_cmp++;
      step();
    end
    data_ok    = 1'b1;
    data_rdata = 32'hDEADBEEF;
    #1;
    if (ms_to_valid !== 1'b1 || ws_bus.result !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL lw_resp valid=%b res=%h want 1 deadbeef",
               ms_to_valid, ws_bus.result);
    end
    n_cmp++;
    step();
    idle();
    #1;
    if (ms_to_valid !== 1'b0 || ms_allowin !== 1'b1) begin
      n_err++;
      $display("FAIL lw_leave valid=%b allowin=%b want 0 1",
               ms_to_valid, ms_allowin);
    end
    n_cmp++;
  endtask

  task automatic test_extract();
    ld_op_t      ops[3] = '{LD_LB, LD_LBU, LD_LH};
    logic [1:0]  adr[3] = '{2'd3, 2'd3, 2'd2};
    logic [31:0] exp[3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011};
    for (int i = 0; i < 3; i++) begin
      idle();
      issue(mk(ops[i], 1, 1, 0, {30'h400, adr[i]}, 5'd7, 1));
      data_ok    = 1'b1;
      data_rdata = 32'h80112233;
      #1;
      if (ms_to_valid !== 1'b1 || ws_bus.result !== exp[i]) begin
        n_err++;
        $display("FAIL extract_%0d valid=%b res=%h want 1 %h",
                 i, ms_to_valid, ws_bus.result, exp[i]);
      end
      n_cmp++;
      step();
    end
    idle();
  endtask

  task automatic test_backpressure();
    idle();
    issue(mk(LD_LW, 1, 1, 0, 32'h2000, 5'd9, 1));
    ws_allowin = 1'b0;
    data_ok    = 1'b1;
    data_rdata = 32'h12345678;
    step();
    data_ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_rdata = $urandom;
      #1;
      if (ms_to_valid !== 1'b1 || ws_bus.result !== 32'h12345678
          || ms_allowin !== 1'b0) begin
        n_err++;
        $display("FAIL hold_%0d valid=%b res=%h allowin=%b want 1 12345678 0",
                 i, ms_to_valid, ws_bus.result, ms_allowin);
      end
      n_cmp++;
      step();
    end
    ws_allowin = 1'b1;
    #1;
    if (ws_bus.result !== 32'h12345678 || ms_allowin !== 1'b1) begin
      n_err++;
      $display("FAIL hold_release res=%h allowin=%b want 12345678 1",
               ws_bus.result, ms_allowin);
    end
    n_cmp++;
    step();
    idle();
  endtask

  task automatic test_flush_cancel();
    logic [31:0] d;
    idle();
    issue(mk(LD_LW, 1, 1, 0, 32'h3000, 5'd3, 1));
    pipeline_flush  = 1'b1;
    es_req_inflight = 1'b1;
    step();
    idle();
    #1;
    if (dut.cancel_cnt_q !== 2'd2 || ms_to_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_cnt cnt=%0d valid=%b want 2 0",
               dut.cancel_cnt_q, ms_to_valid);
    end
    n_cmp++;
    issue(mk(LD_LW, 1, 1, 0, 32'h3004, 5'd4, 1));
    for (int i = 0; i < 2; i++) begin
      data_ok    = 1'b1;
      data_rdata = 32'hBAD0_0000 + i;
      #1;
      if (ms_to_valid !== 1'b0) begin
        n_err++;
        $display("FAIL drop_%0d valid=%b want 0", i, ms_to_valid);
      end
      n_cmp++;
      step();
    end
    d          = $urandom;
    data_ok    = 1'b1;
    data_rdata = d;
    #1;
    if (ms_to_valid !== 1'b1 || ws_bus.result !== d) begin
      n_err++;
      $display("FAIL after_drop valid=%b res=%h want 1 %h",
               ms_to_valid, ws_bus.result, d);
    end
    n_cmp++;
    step();
    idle();
  endtask

  task automatic test_exception();
    idle();
    issue(mk(LD_LW, 1, 1, 1, 32'h0000_4001, 5'd6, 1));
    if (ms_to_valid !== 1'b1 || ws_bus.result !== 32'h4001
        || ms_load_stall !== 1'b0 || ws_bus.exception.ex !== 1'b1) begin
      n_err++;
      $display("FAIL exc valid=%b res=%h stall=%b ex=%b want 1 4001 0 1",
               ms_to_valid, ws_bus.result, ms_load_stall,
               ws_bus.exception.ex);
    end
    n_cmp++;
    step();
    if (ms_to_valid !== 1'b0) begin
      n_err++;
      $display("FAIL exc_leave valid=%b want 0", ms_to_valid);
    end
    n_cmp++;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    idle();
    pipeline_flush  = 1'b1;
    es_req_inflight = 1'b1;
    step();
    step();
    idle();
    issue(mk(LD_LW, 1, 1, 0, 32'h5000, 5'd8, 1));
    data_ok = 1'b1;
    step();
    data_ok = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    if ({dut.ms_valid_q, dut.buf_valid_q, dut.cancel_cnt_q} !== 4'b0
        || ms_allowin !== 1'b1) begin
      n_err++;
      $display("FAIL async_rst v=%b b=%b c=%0d allowin=%b want 0 0 0 1",
               dut.ms_valid_q, dut.buf_valid_q, dut.cancel_cnt_q,
               ms_allowin);
    end
    n_cmp++;
    step();
    reset = 1'b0;
    issue(mk(LD_LW, 1, 1, 0, 32'h5004, 5'd8, 1));
    d          = $urandom;
    data_ok    = 1'b1;
    data_rdata = d;
    #1;
    if (ms_to_valid !== 1'b1 || ws_bus.result !== d) begin
      n_err++;
      $display("FAIL post_rst valid=%b res=%h want 1 %h",
               ms_to_valid, ws_bus.result, d);
    end
    n_cmp++;
    step();
    idle();
  endtask

`ifdef MEM_UNALIGNED_LOAD_EN
  task automatic test_lwl();
    es_to_ms_bus_t b;
    idle();
    b = mk(LD_LWL, 1, 1, 0, 32'h6001, 5'd2, 1);
    b.rt_value = 32'h11223344;
    issue(b);
    data_ok    = 1'b1;
    data_rdata = 32'hAABBCCDD;
    #1;
    if (ws_bus.result !== 32'hCCDD3344 || ws_bus.rf_we !== 4'b1100) begin
      n_err++;
      $display("FAIL lwl res=%h we=%b want ccdd3344 1100",
               ws_bus.result, ws_bus.rf_we);
    end
    n_cmp++;
    step();
    idle();
  endtask
`endif

  task automatic test_random(input int n);
    es_to_ms_bus_t b;
    logic [35:0]   r;
    logic [31:0]   d, exp_res;
    logic [3:0]    exp_we;
    logic          need;
    int            dly, k;
    for (int t = 0; t < n; t++) begin
      idle();
      b = mk(ld_op_t'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0),
             1'b0, ($urandom_range(0, 9) == 0), $urandom,
             5'($urandom), 1'($urandom));
      b.mem_req = b.is_load | 1'($urandom);
      need = b.mem_req & ~b.exception.ex;
      d    = $urandom;
      r    = ref_load(b.ld_op, b.result[1:0], d, get_rt(b));
      exp_res = (b.is_load & need) ? r[31:0] : b.result;
      exp_we  = ~b.rf_we ? 4'h0 : ((b.is_load & need) ? r[35:32] : 4'hf);
      if (ms_allowin !== 1'b1) begin
        n_err++;
        $display("FAIL rnd%0d_allowin got %b want 1", t, ms_allowin);
      end
      n_cmp++;
      issue(b);
      dly = need ? $urandom_range(0, 3) : 0;
      k   = $urandom_range(0, 2);
      repeat (dly) begin
        if (ms_to_valid !== 1'b0
            || ms_load_stall !== b.is_load) begin
          n_err++;
          $display("FAIL rnd%0d_wait valid=%b stall=%b want 0 %b",
                   t, ms_to_valid, ms_load_stall, b.is_load);
        end
        n_cmp++;
        step();
      end
      ws_allowin = (k == 0);
      data_ok    = need;
      data_rdata = d;
      #1;
      if (ms_to_valid !== 1'b1 || ws_bus.result !== exp_res
          || ws_bus.rf_we !== exp_we) begin
        n_err++;
        $display("FAIL rnd%0d_out op=%0d v=%b res=%h we=%b want 1 %h %b",
                 t, b.ld_op, ms_to_valid, ws_bus.result, ws_bus.rf_we,
                 exp_res, exp_we);
      end
      n_cmp++;
      step();
      data_ok    = 1'b0;
      data_rdata = $urandom;
      if (k != 0) begin
        repeat (k - 1) step();
        ws_allowin = 1'b1;
        #1;
        if (ms_to_valid !== 1'b1 || ws_bus.result !== exp_res) begin
          n_err++;
          $display("FAIL rnd%0d_late v=%b res=%h want 1 %h",
                   t, ms_to_valid, ws_bus.result, exp_res);
        end
        n_cmp++;
        step();
      end
      if (ms_to_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rnd%0d_gone valid=%b want 0", t, ms_to_valid);
      end
      n_cmp++;
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_lw_latency();
    test_extract();
    test_backpressure();
    test_flush_cancel();
    test_exception();
    test_async_reset();
`ifdef MEM_UNALIGNED_LOAD_EN
    test_lwl();
`endif
    test_random(60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
